adc_frame_tx: RTL

- Transmit-side frame generator for the ADC LVDS-style link.
- Produces the DCO-domain frame clock marker (fco_out) every FRAME_PERIOD cycles and serializes one parallel sample word per frame, MSB first, on dout.
- Feeds the FCO alignment monitor and deserializer in loopback benches and emulation builds.
- A fault-injection input forces one frame of non-nominal length so the receive-side mismatch and error-count paths can be exercised.

---
 rtl/adc_frame_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/adc_frame_tx.sv
// Transmit-side ADC frame generator: emits a one-cycle frame marker on fco_out and
// serializes one sample word per frame MSB first on dout, with optional off-length frame injection.
module adc_frame_tx #(
    parameter int FRAME_PERIOD = 8,
    parameter int SLIP_W       = 4,
    parameter int CNT_W        = 16
) (
    input  logic                    dco_clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [FRAME_PERIOD-1:0] sample_data,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    slip_req,
    input  logic [SLIP_W-1:0]       slip_amt,
    output logic                    fco_out,
    output logic                    dout,
    output logic                    underrun_pulse,
    output logic [CNT_W-1:0]        frame_count
);

    localparam int SLIP_MAX = (1 << SLIP_W) - 1;
    localparam int MAX_LEN  = (FRAME_PERIOD > SLIP_MAX) ? FRAME_PERIOD : SLIP_MAX;
    localparam int LEN_W    = $clog2(MAX_LEN + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [LEN_W-1:0]        bit_cnt;
    logic [LEN_W-1:0]        frame_len;
    logic [LEN_W-1:0]        slip_len;
    logic [FRAME_PERIOD-1:0] shreg;
    logic                    slip_pending;
    logic                    last_bit;
    logic                    load;

    // A load edge either starts framing from IDLE or chains straight into the next frame.
    always_comb begin
        state_next = state;
        last_bit   = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                load = en;
                if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                last_bit = (bit_cnt == frame_len - LEN_W'(1));
                load     = last_bit && en;
                if (last_bit && !en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sample_ready = load;
    assign slip_len     = (int'(slip_amt) < 2) ? LEN_W'(2) : LEN_W'(slip_amt);

    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frames longer than the word shift out zero fill; shorter ones drop the LSBs.
    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            fco_out        <= 1'b0;
            dout           <= 1'b0;
            underrun_pulse <= 1'b0;
            frame_count    <= '0;
            bit_cnt        <= '0;
            frame_len      <= LEN_W'(FRAME_PERIOD);
            shreg          <= '0;
            slip_pending   <= 1'b0;
        end else begin
            if (load) begin
                fco_out     <= 1'b1;
                bit_cnt     <= '0;
                frame_count <= frame_count + CNT_W'(1);
                frame_len   <= slip_pending ? slip_len : LEN_W'(FRAME_PERIOD);
                if (sample_valid) begin
                    shreg          <= sample_data;
                    dout           <= sample_data[FRAME_PERIOD-1];
                    underrun_pulse <= 1'b0;
                end else begin
                    shreg          <= '0;
                    dout           <= 1'b0;
                    underrun_pulse <= 1'b1;
                end
            end else if (state == RUN && !last_bit) begin
                fco_out        <= 1'b0;
                underrun_pulse <= 1'b0;
                shreg          <= shreg << 1;
                dout           <= shreg[FRAME_PERIOD-2];
                bit_cnt        <= bit_cnt + LEN_W'(1);
            end else begin
                fco_out        <= 1'b0;
                underrun_pulse <= 1'b0;
                dout           <= 1'b0;
                shreg          <= '0;
                bit_cnt        <= '0;
            end

            if (load && slip_pending) begin
                slip_pending <= 1'b0;
            end else if (slip_req) begin
                slip_pending <= 1'b1;
            end
        end
    end

endmodule
